// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - opcodes, keypad codes and session state encoding for the ATM front end
package atm_pkg;

  localparam logic [2:0] OP_IDLE       = 3'b000;
  localparam logic [2:0] OP_BALANCE    = 3'b001;
  localparam logic [2:0] OP_WITHDRAW   = 3'b010;
  localparam logic [2:0] OP_TRANSFER   = 3'b011;
  localparam logic [2:0] OP_REPORT     = 3'b100;
  localparam logic [2:0] OP_CHANGE_PIN = 3'b101;
  localparam logic [2:0] OP_DEPOSIT    = 3'b110;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN,
    ST_MENU,
    ST_AMOUNT,
    ST_TARGET,
    ST_ISSUE,
    ST_RESP,
    ST_LOCKED
  } state_e;

  // States in which the customer is interacting with the keypad
  function automatic logic is_entry_state(input state_e s);
    return (s == ST_PIN) || (s == ST_MENU) || (s == ST_AMOUNT) || (s == ST_TARGET);
  endfunction

endpackage

// File: rtl/atm_digit_accum.sv
// rtl/atm_digit_accum.sv - decimal keypad accumulator, saturating at MAX_DIGITS digits
module atm_digit_accum #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [9:0] value,
  output logic [1:0] count
);

  logic [9:0] value_q, value_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr) begin
      value_d = '0;
      count_d = '0;
    end else if (digit_valid && (int'(count_q) < MAX_DIGITS)) begin
      value_d = value_q * 10'd10 + {6'd0, digit};
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value = value_q;
  assign count = count_q;

endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session controller: card/PIN/menu entry, opcode issue, lockout.
// Optional inactivity timeout enabled by defining ATM_SESSION_TIMEOUT_EN.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_DIGITS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       card_present,
  input  logic [9:0] card_no_in,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       card_declined,
  output logic [2:0] operation,
  output logic [9:0] card_no,
  output logic [9:0] card_pin,
  output logic [9:0] amount,
  output logic [9:0] target_no,
  output logic       locked,
  output logic       session_abort
);

  localparam int FW = $clog2(MAX_ATTEMPTS + 1);

  state_e          state_q, state_d;
  logic            card_prev_q;
  logic [2:0]      op_q, op_d;
  logic [9:0]      card_no_q, card_no_d, pin_q, pin_d, amt_q, amt_d, tgt_q, tgt_d;
  logic [9:0]      locked_card_q, locked_card_d;
  logic            locked_valid_q, locked_valid_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            abort_q, abort_d;

  logic [9:0]      acc_value;
  logic [1:0]      acc_count;
  logic            acc_clr, acc_digit;
  logic            is_digit, key_enter, key_cancel, key_clear;
  logic            in_entry, in_data, card_rise, tmo_hit;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);
  assign key_clear  = key_valid && (key_code == KEY_CLEAR);
  assign in_entry   = is_entry_state(state_q);
  assign in_data    = (state_q == ST_PIN) || (state_q == ST_AMOUNT) || (state_q == ST_TARGET);
  assign card_rise  = card_present && !card_prev_q;

`ifdef ATM_SESSION_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign tmo_hit = in_entry && !key_valid && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
  assign tmo_d   = (!in_entry || key_valid || (state_d != state_q)) ? 16'd0 : tmo_q + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit inactivity counter");
  end

  // Every state change restarts entry; digits only count where a value is being typed
  assign acc_clr   = (state_d != state_q) || (key_clear && in_entry);
  assign acc_digit = is_digit && in_data;

  atm_digit_accum #(.MAX_DIGITS(MAX_DIGITS)) u_accum (
    .clk         (clk),
    .reset       (reset),
    .clr         (acc_clr),
    .digit_valid (acc_digit),
    .digit       (key_code),
    .value       (acc_value),
    .count       (acc_count)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    card_no_d      = card_no_q;
    pin_d          = pin_q;
    amt_d          = amt_q;
    tgt_d          = tgt_q;
    locked_card_d  = locked_card_q;
    locked_valid_d = locked_valid_q;
    fail_d         = fail_q;
    abort_d        = 1'b0;

    if (!card_present) begin
      state_d   = ST_IDLE;
      card_no_d = '0;
      pin_d     = '0;
      amt_d     = '0;
      tgt_d     = '0;
    end else if (in_entry && (key_cancel || tmo_hit)) begin
      abort_d = 1'b1;
      pin_d   = '0;
      amt_d   = '0;
      tgt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (card_rise) begin
            if (locked_valid_q && (card_no_in == locked_card_q)) begin
              state_d = ST_LOCKED;
            end else begin
              card_no_d = card_no_in;
              fail_d    = '0;
              state_d   = ST_PIN;
            end
          end
        end
        ST_PIN: begin
          if (key_enter && (acc_count != 2'd0)) begin
            pin_d   = acc_value;
            state_d = ST_MENU;
          end
        end
        ST_MENU: begin
          if (is_digit && !key_code[3]) begin
            case (key_code[2:0])
              OP_BALANCE, OP_REPORT: begin
                op_d    = key_code[2:0];
                state_d = ST_ISSUE;
              end
              OP_WITHDRAW, OP_TRANSFER, OP_DEPOSIT: begin
                op_d    = key_code[2:0];
                state_d = ST_AMOUNT;
              end
              OP_CHANGE_PIN: begin
                op_d    = key_code[2:0];
                state_d = ST_TARGET;
              end
              default: ;
            endcase
          end
        end
        ST_AMOUNT: begin
          if (key_enter && (acc_value != 10'd0)) begin
            amt_d   = acc_value;
            state_d = (op_q == OP_TRANSFER) ? ST_TARGET : ST_ISSUE;
          end
        end
        ST_TARGET: begin
          if (key_enter) begin
            tgt_d   = acc_value;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: state_d = ST_RESP;
        ST_RESP: begin
          if (card_declined) begin
            fail_d = fail_q + FW'(1);
            if (int'(fail_q) + 1 >= MAX_ATTEMPTS) begin
              locked_card_d  = card_no_q;
              locked_valid_d = 1'b1;
              state_d        = ST_LOCKED;
            end else begin
              pin_d   = '0;
              state_d = ST_PIN;
            end
          end else begin
            fail_d = '0;
            if (op_q == OP_CHANGE_PIN) pin_d = tgt_q;
            state_d = ST_MENU;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      card_prev_q    <= 1'b0;
      op_q           <= OP_IDLE;
      card_no_q      <= '0;
      pin_q          <= '0;
      amt_q          <= '0;
      tgt_q          <= '0;
      locked_card_q  <= '0;
      locked_valid_q <= 1'b0;
      fail_q         <= '0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      card_prev_q    <= card_present;
      op_q           <= op_d;
      card_no_q      <= card_no_d;
      pin_q          <= pin_d;
      amt_q          <= amt_d;
      tgt_q          <= tgt_d;
      locked_card_q  <= locked_card_d;
      locked_valid_q <= locked_valid_d;
      fail_q         <= fail_d;
      abort_q        <= abort_d;
    end
  end

  assign operation     = (state_q == ST_ISSUE) ? op_q : OP_IDLE;
  assign card_no       = card_no_q;
  assign card_pin      = pin_q;
  assign amount        = amt_q;
  assign target_no     = tgt_q;
  assign locked        = (state_q == ST_LOCKED);
  assign session_abort = abort_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - self-checking bench for atm_session_ctrl (vectors, corner sequences, random vs model)
module tb_atm_session_ctrl;

  localparam int TMO = 20;
  localparam int PH_IDLE = 0, PH_PIN = 1, PH_MENU = 2, PH_AMOUNT = 3,
                 PH_TARGET = 4, PH_ISSUE = 5, PH_RESP = 6, PH_LOCKED = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cp = 1'b0;
  logic [9:0] cno = '0;
  logic       kv = 1'b0;
  logic [3:0] kc = '0;
  logic       decl = 1'b0;
  logic [2:0] operation;
  logic [9:0] card_no, card_pin, amount, target_no;
  logic       locked, session_abort;

  atm_session_ctrl #(.MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(TMO), .MAX_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .card_present(cp), .card_no_in(cno),
    .key_valid(kv), .key_code(kc), .card_declined(decl),
    .operation(operation), .card_no(card_no), .card_pin(card_pin), .amount(amount),
    .target_no(target_no), .locked(locked), .session_abort(session_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    kv = 1'b1;
    kc = k;
    step();
    kv = 1'b0;
  endtask

  function automatic logic [44:0] outs();
    return {operation, card_no, card_pin, amount, target_no, locked, session_abort};
  endfunction

  // Reference model of the session rules
  int          m_ph;
  logic        m_prev, m_lock_v, m_abort;
  logic [2:0]  m_op;
  logic [9:0]  m_card, m_pin, m_amt, m_tgt, m_lock_card;
  int          m_fail, m_idle;
  int          m_digits[$];

  task automatic model_reset();
    m_ph = PH_IDLE; m_prev = 0; m_lock_v = 0; m_abort = 0; m_op = 0;
    m_card = 0; m_pin = 0; m_amt = 0; m_tgt = 0; m_lock_card = 0;
    m_fail = 0; m_idle = 0; m_digits.delete();
  endtask

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic model_clock();
    int   nx    = m_ph;
    bit   ab    = 0;
    bit   ent   = (m_ph >= PH_PIN) && (m_ph <= PH_TARGET);
    bit   dat   = (m_ph == PH_PIN) || (m_ph == PH_AMOUNT) || (m_ph == PH_TARGET);
    bit   enter = kv && (kc == 4'hA);
    bit   kd    = kv && (kc <= 4'd9);
    bit   tmo   = 0;
    int   val   = digits_value();
`ifdef ATM_SESSION_TIMEOUT_EN
    tmo = ent && !kv && (m_idle + 1 >= TMO);
`endif
    if (!cp) begin
      nx = PH_IDLE; m_card = 0; m_pin = 0; m_amt = 0; m_tgt = 0;
    end else if (ent && ((kv && kc == 4'hB) || tmo)) begin
      ab = 1; m_pin = 0; m_amt = 0; m_tgt = 0; nx = PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE:
          if (!m_prev) begin
            if (m_lock_v && cno == m_lock_card) nx = PH_LOCKED;
            else begin m_card = cno; m_fail = 0; nx = PH_PIN; end
          end
        PH_PIN:
          if (enter && m_digits.size() > 0) begin m_pin = 10'(val); nx = PH_MENU; end
        PH_MENU:
          if (kd && kc >= 1 && kc <= 6) begin
            m_op = kc[2:0];
            if (kc == 1 || kc == 4) nx = PH_ISSUE;
            else if (kc == 5) nx = PH_TARGET;
            else nx = PH_AMOUNT;
          end
        PH_AMOUNT:
          if (enter && val != 0) begin m_amt = 10'(val); nx = (m_op == 3) ? PH_TARGET : PH_ISSUE; end
        PH_TARGET:
          if (enter) begin m_tgt = 10'(val); nx = PH_ISSUE; end
        PH_ISSUE: nx = PH_RESP;
        PH_RESP:
          if (decl) begin
            m_fail++;
            if (m_fail >= 3) begin m_lock_card = m_card; m_lock_v = 1; nx = PH_LOCKED; end
            else begin m_pin = 0; nx = PH_PIN; end
          end else begin
            m_fail = 0;
            if (m_op == 5) m_pin = m_tgt;
            nx = PH_MENU;
          end
        default: ;
      endcase
    end
    if (nx != m_ph || kv || !ent) m_idle = 0;
    else m_idle++;
    if (nx != m_ph) m_digits.delete();
    else if (dat && kd && m_digits.size() < 3) m_digits.push_back(int'(kc));
    else if (ent && kv && kc == 4'hC) m_digits.delete();
    m_prev = cp;
    m_ph = nx;
    m_abort = ab;
  endtask

  function automatic logic [44:0] model_outs();
    logic [2:0] op = (m_ph == PH_ISSUE) ? m_op : 3'd0;
    return {op, m_card, m_pin, m_amt, m_tgt, (m_ph == PH_LOCKED) ? 1'b1 : 1'b0, m_abort};
  endfunction

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       decl;
    logic [2:0] op;
    logic [9:0] pin, amt, tgt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic k_v, input logic [3:0] k_c, input logic d,
                               input logic [2:0] op, input logic [9:0] pin, amt, tgt);
    vec_t v;
    v.kv = k_v; v.kc = k_c; v.decl = d; v.op = op; v.pin = pin; v.amt = amt; v.tgt = tgt;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;

    // Card 100: PIN 100, balance, withdraw 20, change PIN to 999, ignored menu keys, report
    tbl.push_back(mkv(0, 4'h0, 0, 0,   0,  0,   0));
    tbl.push_back(mkv(1, 4'h1, 0, 0,   0,  0,   0));
    tbl.push_back(mkv(1, 4'h0, 0, 0,   0,  0,   0));
    tbl.push_back(mkv(1, 4'h0, 0, 0,   0,  0,   0));
    tbl.push_back(mkv(1, 4'hA, 0, 0, 100,  0,   0));
    tbl.push_back(mkv(1, 4'h1, 0, 1, 100,  0,   0));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 100,  0,   0));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 100,  0,   0));
    tbl.push_back(mkv(1, 4'h2, 0, 0, 100,  0,   0));
    tbl.push_back(mkv(1, 4'h2, 0, 0, 100,  0,   0));
    tbl.push_back(mkv(1, 4'h0, 0, 0, 100,  0,   0));
    tbl.push_back(mkv(1, 4'hA, 0, 2, 100, 20,   0));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 100, 20,   0));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 100, 20,   0));
    tbl.push_back(mkv(1, 4'h5, 0, 0, 100, 20,   0));
    tbl.push_back(mkv(1, 4'h9, 0, 0, 100, 20,   0));
    tbl.push_back(mkv(1, 4'h9, 0, 0, 100, 20,   0));
    tbl.push_back(mkv(1, 4'h9, 0, 0, 100, 20,   0));
    tbl.push_back(mkv(1, 4'hA, 0, 5, 100, 20, 999));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 100, 20, 999));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 999, 20, 999));
    tbl.push_back(mkv(1, 4'hD, 0, 0, 999, 20, 999));
    tbl.push_back(mkv(1, 4'h7, 0, 0, 999, 20, 999));
    tbl.push_back(mkv(1, 4'h0, 0, 0, 999, 20, 999));
    tbl.push_back(mkv(1, 4'h4, 0, 4, 999, 20, 999));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 999, 20, 999));
    tbl.push_back(mkv(0, 4'h0, 0, 0, 999, 20, 999));

    step();
    chk("reset_outputs", outs(), 45'd0);
    reset = 1'b1;

    cp = 1'b1; cno = 10'd100;
    for (int i = 0; i < tbl.size(); i++) begin
      kv = tbl[i].kv; kc = tbl[i].kc; decl = tbl[i].decl;
      step();
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].op, 10'd100, tbl[i].pin, tbl[i].amt, tbl[i].tgt, 2'b00});
    end
    kv = 1'b0;

    // Three consecutive declines lock card 100
    for (int a = 1; a <= 3; a++) begin
      key(4'h1);
      chk($sformatf("lock_issue%0d", a), operation, 3'd1);
      step();
      decl = 1'b1; step(); decl = 1'b0;
      if (a < 3) begin
        chk($sformatf("lock_pending%0d", a), {locked, card_pin}, {1'b0, 10'd0});
        key(4'h9); key(4'h9); key(4'h9); key(4'hA);
      end else begin
        chk("lock_set", locked, 1'b1);
      end
    end
    key(4'h1);
    chk("locked_keys_ignored", {locked, operation}, {1'b1, 3'd0});
    cp = 1'b0; step();
    chk("locked_removed", {locked, card_no}, {1'b0, 10'd0});
    cp = 1'b1; step();
    chk("locked_reinsert", locked, 1'b1);
    cp = 1'b0; step();
    cno = 10'd101; cp = 1'b1; step();
    chk("other_card_ok", {locked, card_no}, {1'b0, 10'd101});

    // Transfer with ignored zero-amount ENTERs
    key(4'h1); key(4'hA); key(4'h3);
    key(4'hA);
    chk("amount_enter_empty", {operation, amount}, {3'd0, 10'd0});
    key(4'h0); key(4'hA);
    chk("amount_enter_zero", {operation, amount}, {3'd0, 10'd0});
    key(4'h5); key(4'h0); key(4'hA);
    chk("transfer_amount", {operation, amount}, {3'd0, 10'd50});
    key(4'h2); key(4'h0); key(4'h0); key(4'hA);
    chk("transfer_issue", {operation, amount, target_no}, {3'd3, 10'd50, 10'd200});
    step(); step();

    // Digit saturation on PIN change, then CLEAR during amount entry
    key(4'h5); key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hA);
    chk("saturate_target", {operation, target_no}, {3'd5, 10'd123});
    step(); step();
    chk("pin_changed", card_pin, 10'd123);
    key(4'h2); key(4'h8); key(4'hC); key(4'h6); key(4'hA);
    chk("clear_amount", {operation, amount}, {3'd2, 10'd6});
    step(); step();

    // CANCEL during amount entry
    key(4'h2); key(4'h3); key(4'hB);
    chk("cancel_pulse", {session_abort, card_no, card_pin, amount, target_no},
        {1'b1, 10'd101, 10'd0, 10'd0, 10'd0});
    step();
    chk("cancel_pulse_end", session_abort, 1'b0);

    // Card pulled while typing an amount
    cp = 1'b0; step(); cp = 1'b1; step();
    key(4'h4); key(4'hA); key(4'h2); key(4'h7);
    cp = 1'b0; step();
    chk("removal_clears", outs(), 45'd0);

    // Idle in MENU
    cp = 1'b1; step();
    key(4'h4); key(4'hA);
    seen = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (session_abort && seen < 0) seen = c;
    end
`ifdef ATM_SESSION_TIMEOUT_EN
    chk("timeout_cycle", seen, TMO);
`else
    chk("no_timeout", seen, -1);
    key(4'h1);
    chk("menu_alive", operation, 3'd1);
    step(); step();
`endif

    // Asynchronous reset mid-MENU, also forgets the locked card
    cp = 1'b0; step(); cp = 1'b1; step();
    key(4'h4); key(4'hA);
    @(posedge clk); #3; reset = 1'b0; #1;
    chk("async_reset", outs(), 45'd0);
    step(); reset = 1'b1;
    cp = 1'b0; step();
    cno = 10'd100; cp = 1'b1; step();
    chk("lock_forgotten", {locked, card_no}, {1'b0, 10'd100});

    // Random traffic against the model
    cp = 1'b0; reset = 1'b0; step(); reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      if (cp) begin
        if ($urandom_range(0, 79) == 0) cp = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        cp = 1'b1;
        case ($urandom_range(0, 3))
          0, 1:    cno = 10'd100;
          2:       cno = 10'd101;
          default: cno = 10'($urandom_range(0, 1023));
        endcase
      end
      kv = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 19);
      if (r <= 9)       kc = 4'(r);
      else if (r <= 13) kc = 4'hA;
      else if (r == 14) kc = 4'hB;
      else if (r == 15) kc = 4'hC;
      else if (r == 16) kc = 4'(13 + $urandom_range(0, 2));
      else              kc = 4'(r - 16);
      decl = ($urandom_range(0, 2) == 0);
      model_clock();
      step();
      chk($sformatf("rand%0d", i), outs(), model_outs());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
